// File: rtl/vertex_fetch.sv
// Vertex fetch: streams TRI_COUNT mesh records from a synchronous ROM
// into a small first-word-fall-through buffer, one frame per nextFrame.
module vertex_fetch #(
  parameter int TRI_COUNT  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk100,
  input  logic         rst_n,
  input  logic         nextFrame,
  output logic [7:0]   Mesh_Addr,
  input  logic [223:0] Mesh_Data,
  output logic [223:0] VertexBuffer_PreCalc_ReadData,
  input  logic         VertexBuffer_PreCalc_pop,
  output logic         VertexBuffer_PreCalc_empty,
  output logic         frameDone
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam logic [7:0]  LAST  = 8'(TRI_COUNT - 1);
  localparam logic [OW:0] DEPTH = (OW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [7:0]      addr_q, addr_d;
  logic [OW-1:0]   occ_q, occ_d;
  logic            infl_q, infl_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [223:0]    head_q, head_d;
  logic            done_q, done_d;
  logic [223:0]    mem_q [FIFO_DEPTH];

  logic flush;
  logic pop_ok;
  logic push;
  logic issue;

  always_comb begin
    flush   = nextFrame;
    pop_ok  = VertexBuffer_PreCalc_pop && (occ_q != '0) && !flush;
    push    = infl_q && !flush;
    issue   = (state_q == FETCH) && !flush &&
              (({1'b0, occ_q} + {{OW{1'b0}}, infl_q}) < DEPTH);
    state_d = state_q;
    addr_d  = addr_q;
    infl_d  = issue;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: ;
      FETCH: begin
        if (issue) begin
          if (addr_q == LAST) state_d = DRAIN;
          else addr_d = addr_q + 8'd1;
        end
      end
      DRAIN: begin
        if ((occ_q == '0) && !infl_q) begin
          state_d = IDLE;
          done_d  = !flush;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = FETCH;
      addr_d  = '0;
    end
    occ_d = flush ? '0 : occ_q + OW'(push) - OW'(pop_ok);
    rd_d  = flush ? '0 : rd_q + PW'(pop_ok);
    wr_d  = flush ? '0 : wr_q + PW'(push);
    // New head comes straight from the ROM when the buffer was otherwise empty
    head_d = head_q;
    if (occ_d != '0) begin
      head_d = (occ_q == OW'(pop_ok)) ? Mesh_Data : mem_q[rd_d];
    end
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      occ_q   <= '0;
      infl_q  <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      head_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      occ_q   <= occ_d;
      infl_q  <= infl_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      head_q  <= head_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk100) begin
    if (push) mem_q[wr_q] <= Mesh_Data;
  end

  assign Mesh_Addr                     = addr_q;
  assign VertexBuffer_PreCalc_ReadData = head_q;
  assign VertexBuffer_PreCalc_empty    = (occ_q == '0);
  assign frameDone                     = done_q;

endmodule
